monox_job_sched: RTL and testbench

MONOX_JOB_SCHED -- requirements
Module: monox_job_sched

---
 rtl/monox_job_sched_pkg.sv | 25 ++
 rtl/monox_cmd_fifo.sv | 62 ++++++
 rtl/monox_job_sched.sv | 149 ++++++++++++++
 tb/tb_monox_job_sched.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/monox_job_sched_pkg.sv
// Shared definitions for the monox job scheduler: FSM state encoding and default abort limit.
package monox_job_sched_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_RUN   = 3'd2;
  localparam logic [2:0] ST_FLUSH = 3'd3;
  localparam logic [2:0] ST_RESP  = 3'd4;

  typedef enum logic [2:0] {
    StIdle  = ST_IDLE,
    StStart = ST_START,
    StRun   = ST_RUN,
    StFlush = ST_FLUSH,
    StResp  = ST_RESP
  } state_e;

  localparam logic [15:0] DEFAULT_TIMEOUT_CYCLES = 16'd8192;

  // Completed-job counter rolls over from 16'hFFFF to 0.
  function automatic logic [15:0] inc_wrap16(input logic [15:0] v);
    return v + 16'd1;
  endfunction

endpackage

// File: rtl/monox_cmd_fifo.sv
// Registered command FIFO: no bypass, full/empty are flops so readiness never depends on a pop.
module monox_cmd_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      cnt_q, cnt_d;
  logic             full_q, empty_q;
  logic             do_push, do_pop;

  // A pop against a registered-empty FIFO is dropped, even if a push lands this cycle.
  assign do_push = push & ~full_q;
  assign do_pop  = pop & ~empty_q;

  always_comb begin
    cnt_d = cnt_q;
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + (AW + 1)'(1);
    end else if (!do_push && do_pop) begin
      cnt_d = cnt_q - (AW + 1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      cnt_q   <= cnt_d;
      full_q  <= (cnt_d == FULL_CNT);
      empty_q <= (cnt_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata;
  end

  assign rdata = mem_q[rptr_q];
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/monox_job_sched.sv
// Job scheduler: queues commands, sequences one datapath job at a time with timeout abort,
// and returns a tagged completion response.
module monox_job_sched
  import monox_job_sched_pkg::*;
#(
  parameter int unsigned POWER_WIDTH    = 4,
  parameter int unsigned ID_WIDTH       = 4,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter logic [15:0] TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_cmd_valid,
  output logic                   o_cmd_ready,
  input  logic                   i_cmd_mode,
  input  logic [POWER_WIDTH-1:0] i_cmd_n,
  input  logic                   i_cmd_trace,
  input  logic [ID_WIDTH-1:0]    i_cmd_id,
  output logic                   o_en,
  output logic                   o_start,
  output logic                   o_mode,
  output logic [POWER_WIDTH-1:0] o_n,
  output logic                   o_trace,
  input  logic                   i_done,
  output logic                   o_rsp_valid,
  input  logic                   i_rsp_ready,
  output logic [ID_WIDTH-1:0]    o_rsp_id,
  output logic                   o_rsp_timeout,
  output logic                   o_busy,
  output logic [15:0]            o_jobs_done
);

  localparam int unsigned JW = POWER_WIDTH + ID_WIDTH + 2;

  logic [JW-1:0] fifo_wdata, fifo_rdata;
  logic          fifo_full, fifo_empty, fifo_pop, fifo_push;

  state_e                 state_q, state_d;
  logic [15:0]            cnt_q, cnt_d;
  logic                   tflag_q, tflag_d;
  logic [15:0]            jobs_q, jobs_d;
  logic                   job_mode_q, job_trace_q;
  logic [POWER_WIDTH-1:0] job_n_q;
  logic [ID_WIDTH-1:0]    job_id_q;
  logic                   en_q, start_q, busy_q, rsp_valid_q;

  assign fifo_wdata = {i_cmd_mode, i_cmd_n, i_cmd_trace, i_cmd_id};
  assign fifo_push  = i_cmd_valid & ~fifo_full;

  monox_cmd_fifo #(
    .WIDTH (JW),
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tflag_d  = tflag_q;
    jobs_d   = jobs_q;
    fifo_pop = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = StStart;
        end
      end
      StStart: begin
        cnt_d   = '0;
        state_d = StRun;
      end
      StRun: begin
        cnt_d = cnt_q + 16'd1;
        // Done wins over a timeout landing in the same cycle.
        if (i_done) begin
          tflag_d = 1'b0;
          state_d = StFlush;
        end else if (cnt_q == TIMEOUT_CYCLES - 16'd1) begin
          tflag_d = 1'b1;
          state_d = StFlush;
        end
      end
      StFlush: begin
        state_d = StResp;
      end
      StResp: begin
        if (i_rsp_ready) begin
          state_d = StIdle;
          if (!tflag_q) jobs_d = inc_wrap16(jobs_q);
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Strobes are registered from the next state so they align with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      tflag_q     <= 1'b0;
      jobs_q      <= '0;
      job_mode_q  <= 1'b0;
      job_n_q     <= '0;
      job_trace_q <= 1'b0;
      job_id_q    <= '0;
      en_q        <= 1'b0;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tflag_q     <= tflag_d;
      jobs_q      <= jobs_d;
      en_q        <= (state_d == StStart) || (state_d == StRun);
      start_q     <= (state_d == StStart);
      busy_q      <= (state_d != StIdle);
      rsp_valid_q <= (state_d == StResp);
      if (fifo_pop) begin
        {job_mode_q, job_n_q, job_trace_q, job_id_q} <= fifo_rdata;
      end
    end
  end

  assign o_cmd_ready   = ~fifo_full;
  assign o_en          = en_q;
  assign o_start       = start_q;
  assign o_mode        = job_mode_q;
  assign o_n           = job_n_q;
  assign o_trace       = job_trace_q;
  assign o_rsp_valid   = rsp_valid_q;
  assign o_rsp_id      = job_id_q;
  assign o_rsp_timeout = tflag_q;
  assign o_busy        = busy_q;
  assign o_jobs_done   = jobs_q;

endmodule

// File: tb/tb_monox_job_sched.sv
// Randomized scoreboard bench for monox_job_sched against a cycle-level job model.
module tb_monox_job_sched;

  localparam int TMO   = 16;
  localparam int DEPTH = 4;
  localparam int NCMD  = 40;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_cmd_valid = 1'b0;
  logic        o_cmd_ready;
  logic        i_cmd_mode = 1'b0;
  logic [3:0]  i_cmd_n = '0;
  logic        i_cmd_trace = 1'b0;
  logic [3:0]  i_cmd_id = '0;
  logic        o_en, o_start, o_mode, o_trace;
  logic [3:0]  o_n;
  logic        i_done;
  logic        o_rsp_valid;
  logic        i_rsp_ready = 1'b1;
  logic [3:0]  o_rsp_id;
  logic        o_rsp_timeout;
  logic        o_busy;
  logic [15:0] o_jobs_done;

  monox_job_sched #(
    .POWER_WIDTH    (4),
    .ID_WIDTH       (4),
    .FIFO_DEPTH     (DEPTH),
    .TIMEOUT_CYCLES (16'(TMO))
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_cmd_valid   (i_cmd_valid),
    .o_cmd_ready   (o_cmd_ready),
    .i_cmd_mode    (i_cmd_mode),
    .i_cmd_n       (i_cmd_n),
    .i_cmd_trace   (i_cmd_trace),
    .i_cmd_id      (i_cmd_id),
    .o_en          (o_en),
    .o_start       (o_start),
    .o_mode        (o_mode),
    .o_n           (o_n),
    .o_trace       (o_trace),
    .i_done        (i_done),
    .o_rsp_valid   (o_rsp_valid),
    .i_rsp_ready   (i_rsp_ready),
    .o_rsp_id      (o_rsp_id),
    .o_rsp_timeout (o_rsp_timeout),
    .o_busy        (o_busy),
    .o_jobs_done   (o_jobs_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       mode;
    bit [3:0] n;
    bit       trace;
    bit [3:0] id;
    int       acc;
  } cmd_t;

  cmd_t        cmdq[$];
  bit [3:0]    idq[$];
  bit          tq[$];
  int          cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;
  int          occ = 0;
  int          last_hs = -100;
  logic [15:0] exp_jobs = '0;
  bit          mon_en = 0, dp_en = 0, rdy_en = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_cmd_ready"}, 32'(o_cmd_ready), 1);
    chk({tag, "_en"}, 32'(o_en), 0);
    chk({tag, "_start"}, 32'(o_start), 0);
    chk({tag, "_rsp_valid"}, 32'(o_rsp_valid), 0);
    chk({tag, "_busy"}, 32'(o_busy), 0);
    chk({tag, "_cfg"}, {o_mode, o_n, o_trace}, 0);
    chk({tag, "_rsp_id"}, 32'(o_rsp_id), 0);
    chk({tag, "_rsp_timeout"}, 32'(o_rsp_timeout), 0);
    chk({tag, "_jobs_done"}, 32'(o_jobs_done), 0);
  endtask

  // Scoreboard monitor: occupancy, start timing/config, response content and completion count.
  initial begin : monitor
    cmd_t c;
    int   exp_start;
    bit   jobs_chk = 0;
    bit   exp_to;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (o_start) begin
          occ--;
          if (cmdq.size() == 0) begin
            chk("start_unexpected", 32'(o_start), 0);
          end else begin
            c = cmdq.pop_front();
            exp_start = (c.acc > last_hs) ? c.acc + 2 : last_hs + 2;
            chk("start_cycle", cyc, exp_start);
            chk("start_cfg", {o_mode, o_n, o_trace}, {c.mode, c.n, c.trace});
            chk("start_en", 32'(o_en), 1);
            idq.push_back(c.id);
          end
        end
        chk("cmd_ready", 32'(o_cmd_ready), 32'(occ < DEPTH));
        if (i_cmd_valid && o_cmd_ready) begin
          c.mode  = i_cmd_mode;
          c.n     = i_cmd_n;
          c.trace = i_cmd_trace;
          c.id    = i_cmd_id;
          c.acc   = cyc;
          cmdq.push_back(c);
          occ++;
        end
        if (jobs_chk) begin
          chk("jobs_done", 32'(o_jobs_done), 32'(exp_jobs));
          jobs_chk = 0;
        end
        if (o_rsp_valid) begin
          if (idq.size() == 0 || tq.size() == 0) begin
            chk("rsp_unexpected", 32'(o_rsp_valid), 0);
          end else begin
            chk("rsp_id", 32'(o_rsp_id), 32'(idq[0]));
            chk("rsp_timeout", 32'(o_rsp_timeout), 32'(tq[0]));
            if (i_rsp_ready) begin
              void'(idq.pop_front());
              exp_to = tq.pop_front();
              if (!exp_to) exp_jobs = exp_jobs + 16'd1;
              jobs_chk = 1;
              last_hs  = cyc;
            end
          end
        end
      end
    end
  end

  // Datapath responder: picks a run length per job; beyond TMO means no done (timeout).
  initial begin : responder
    int d, len;
    i_done = 1'b0;
    forever begin
      @(posedge clk); #1;
      i_done = dp_en && ($urandom_range(0, 3) == 0);
      @(negedge clk);
      if (dp_en && o_start) begin
        d   = ($urandom_range(0, 3) == 0) ? TMO + int'($urandom_range(0, 1))
                                          : int'($urandom_range(1, TMO + 4));
        len = (d <= TMO) ? d : TMO;
        tq.push_back(d > TMO);
        for (int k = 1; k <= len; k++) begin
          @(posedge clk); #1;
          i_done = (k == len) && (d <= TMO);
        end
        @(negedge clk);
        chk("en_run", 32'(o_en), 1);
        @(posedge clk); #1;
        i_done = 1'b0;
        @(negedge clk);
        chk("en_flush", 32'(o_en), 0);
        chk("busy_flush", 32'(o_busy), 1);
      end
    end
  end

  initial begin : rsp_ready_drv
    int hold = 0;
    forever begin
      @(posedge clk); #1;
      if (!rdy_en) begin
        i_rsp_ready = 1'b1;
      end else if (hold > 0) begin
        hold--;
        i_rsp_ready = 1'b0;
      end else if ($urandom_range(0, 9) == 0) begin
        hold = 19;
        i_rsp_ready = 1'b0;
      end else begin
        i_rsp_ready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int  gap, budget;
    bit  ok;
    repeat (3) @(negedge clk);
    check_reset("por");
    rst_n  = 1'b1;
    mon_en = 1;
    dp_en  = 1;
    rdy_en = 1;
    @(posedge clk); #1;

    for (int j = 0; j < NCMD; j++) begin
      gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 40)) : 0;
      repeat (gap) begin @(posedge clk); #1; end
      i_cmd_valid = 1'b1;
      i_cmd_mode  = 1'($urandom);
      i_cmd_n     = 4'($urandom);
      i_cmd_trace = 1'($urandom);
      i_cmd_id    = 4'(j);
      budget = 0;
      ok = 0;
      while (!ok && budget < 1000) begin
        @(negedge clk);
        ok = o_cmd_ready;
        budget++;
      end
      if (!ok) chk("cmd_accept_wait", 32'(o_cmd_ready), 1);
      @(posedge clk); #1;
      i_cmd_valid = 1'b0;
    end

    budget = 0;
    ok = 0;
    while (!ok && budget < 3000) begin
      @(negedge clk); #1;
      ok = (cmdq.size() == 0) && (idq.size() == 0) && !o_busy;
      budget++;
    end
    chk("drain_idle", 32'(o_busy), 0);
    chk("drain_jobs_done", 32'(o_jobs_done), 32'(exp_jobs));

    // Reset while a job is running, with more commands queued behind it.
    mon_en = 0;
    dp_en  = 0;
    rdy_en = 0;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      i_cmd_valid = 1'b1;
      i_cmd_id    = 4'(k + 1);
      i_cmd_n     = 4'(k + 5);
      @(posedge clk); #1;
    end
    i_cmd_valid = 1'b0;
    budget = 0;
    ok = 0;
    while (!ok && budget < 20) begin
      @(negedge clk);
      ok = o_start;
      budget++;
    end
    chk("pre_reset_start", 32'(o_start), 1);
    repeat (3) @(negedge clk);
    chk("pre_reset_en", 32'(o_en), 1);
    #2 rst_n = 1'b0;
    #1 check_reset("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("post_rst_start", 32'(o_start), 0);
      chk("post_rst_busy", 32'(o_busy), 0);
      chk("post_rst_ready", 32'(o_cmd_ready), 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
